// File: rtl/bg_write_sched.sv
// Background tile-RAM write scheduler: round-robin producer arbitration, full-map clear sweep, scroll offset timer.
// Optional build macro SCROLL_SPEEDUP_EN: scroll delay latched after reset and shortened on every tile_step.
module bg_write_sched #(
    parameter int unsigned N_CH       = 6,
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned TILE_W     = 16,
    parameter int unsigned MAP_WORDS  = 1200,
    parameter int unsigned CLEAR_DATA = 0,
    parameter int unsigned HUD_PX     = 32,
    parameter int unsigned AUTO_CLEAR = 1
`ifdef SCROLL_SPEEDUP_EN
    ,
    parameter int unsigned MIN_DELAY    = 200000,
    parameter int unsigned SPEEDUP_STEP = 100000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_CH-1:0]    req_valid,
    input  logic [N_CH*AW-1:0] req_addr,
    input  logic [N_CH*DW-1:0] req_data,
    output logic [N_CH-1:0]    req_ready,
    input  logic               clear_start,
    output logic               clear_busy,
    input  logic [31:0]        scroll_delay,
    input  logic [9:0]         y,
    output logic [3:0]         bg_x_offset,
    output logic               tile_step,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_data
);

    localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]    r_state, w_state_n;
    logic [AW-1:0] r_clr_addr, w_clr_addr_n;
    logic          r_busy, w_busy_n;
    logic          r_we, w_we_n;
    logic [AW-1:0] r_addr, w_addr_n;
    logic [DW-1:0] r_data, w_data_n;
    logic [PW-1:0] r_ptr, w_ptr_n;

    logic [31:0]   r_cnt;
    logic [3:0]    r_offset;
    logic          r_tile_step;
    logic [3:0]    r_bgx;

    logic          w_tile_step;
    logic          w_clear_trig;
    logic          w_arb_en;
    logic          w_found;
    logic [PW-1:0] w_gidx;
    logic [PW-1:0] w_gnext;
    logic [N_CH-1:0] w_ready;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;
    logic [31:0]   w_delay;
    logic          w_hit;
    logic          w_wrap;

    // Strobes are masked while frozen so a held write or step is presented once on re-enable.
    assign w_tile_step  = r_tile_step & enable;
    assign w_clear_trig = clear_start | ((AUTO_CLEAR != 0) & w_tile_step);
    assign w_arb_en     = enable & (r_state == ST_IDLE) & ~w_clear_trig;

    // First valid channel searching upward from the round-robin pointer.
    always_comb begin : p_search
        int unsigned idx;
        w_found = 1'b0;
        w_gidx  = '0;
        idx     = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = 32'(r_ptr) + 32'(k);
            if (idx >= N_CH) idx = idx - N_CH;
            if (!w_found && req_valid[PW'(idx)]) begin
                w_found = 1'b1;
                w_gidx  = PW'(idx);
            end
        end
    end

    assign w_gnext = (w_gidx == PW'(N_CH - 1)) ? '0 : w_gidx + 1'b1;

    always_comb begin : p_select
        w_ready    = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gidx == PW'(i)) begin
                w_ready[i] = w_arb_en & w_found;
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin : p_fsm_next
        w_state_n    = r_state;
        w_clr_addr_n = r_clr_addr;
        w_busy_n     = r_busy;
        w_we_n       = 1'b0;
        w_addr_n     = r_addr;
        w_data_n     = r_data;
        w_ptr_n      = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_clear_trig) begin
                    w_state_n    = ST_CLEAR;
                    w_busy_n     = 1'b1;
                    w_clr_addr_n = '0;
                    w_we_n       = 1'b1;
                    w_addr_n     = '0;
                    w_data_n     = DW'(CLEAR_DATA);
                end else if (w_found) begin
                    w_we_n   = 1'b1;
                    w_addr_n = w_sel_addr;
                    w_data_n = w_sel_data;
                    w_ptr_n  = w_gnext;
                end
            end
            ST_CLEAR: begin
                // r_clr_addr is the word being presented this cycle.
                if (r_clr_addr == AW'(MAP_WORDS - 1)) begin
                    w_state_n = ST_IDLE;
                    w_busy_n  = 1'b0;
                end else begin
                    w_clr_addr_n = r_clr_addr + 1'b1;
                    w_we_n       = 1'b1;
                    w_addr_n     = r_clr_addr + 1'b1;
                    w_data_n     = DW'(CLEAR_DATA);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
            r_busy     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_ptr      <= '0;
        end else if (enable) begin
            r_state    <= w_state_n;
            r_clr_addr <= w_clr_addr_n;
            r_busy     <= w_busy_n;
            r_we       <= w_we_n;
            r_addr     <= w_addr_n;
            r_data     <= w_data_n;
            r_ptr      <= w_ptr_n;
        end
    end

`ifdef SCROLL_SPEEDUP_EN
    logic [31:0] r_eff_delay;
    logic        r_eff_loaded;

    // Delay is captured on the first clock after reset, then shortened per tile down to the floor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eff_delay  <= '0;
            r_eff_loaded <= 1'b0;
        end else if (!r_eff_loaded) begin
            r_eff_delay  <= scroll_delay;
            r_eff_loaded <= 1'b1;
        end else if (enable && w_wrap) begin
            if (r_eff_delay <= 32'(MIN_DELAY + SPEEDUP_STEP))
                r_eff_delay <= 32'(MIN_DELAY);
            else
                r_eff_delay <= r_eff_delay - 32'(SPEEDUP_STEP);
        end
    end

    assign w_delay = r_eff_loaded ? r_eff_delay : scroll_delay;
`else
    assign w_delay = scroll_delay;
`endif

    // Magnitude compare so a lowered delay cannot strand the counter past the match point.
    assign w_hit  = (r_cnt >= w_delay);
    assign w_wrap = w_hit & (r_offset == 4'(TILE_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_offset    <= '0;
            r_tile_step <= 1'b0;
            r_bgx       <= '0;
        end else if (enable) begin
            if (w_hit) begin
                r_cnt    <= '0;
                r_offset <= w_wrap ? 4'd0 : r_offset + 4'd1;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            r_tile_step <= w_wrap;
            r_bgx       <= (y < 10'(HUD_PX)) ? 4'd0 : r_offset;
        end
    end

    assign req_ready   = w_ready;
    assign clear_busy  = r_busy;
    assign bg_x_offset = r_bgx;
    assign tile_step   = w_tile_step;
    assign ram_we      = r_we & enable;
    assign ram_addr    = r_addr;
    assign ram_data    = r_data;

endmodule

// File: tb/tb_bg_write_sched.sv
// Directed self-checking bench for bg_write_sched (3 channels, auto-clear off).
module tb_bg_write_sched;

    localparam int unsigned N_CH = 3;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 32;

    logic               clk;
    logic               reset;
    logic               enable;
    logic [N_CH-1:0]    req_valid;
    logic [N_CH*AW-1:0] req_addr;
    logic [N_CH*DW-1:0] req_data;
    logic [N_CH-1:0]    req_ready;
    logic               clear_start;
    logic               clear_busy;
    logic [31:0]        scroll_delay;
    logic [9:0]         y;
    logic [3:0]         bg_x_offset;
    logic               tile_step;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_data;

    int n_vec;
    int n_err;

    bg_write_sched #(
        .N_CH(N_CH), .AW(AW), .DW(DW), .TILE_W(16), .MAP_WORDS(1200),
        .CLEAR_DATA(0), .HUD_PX(32), .AUTO_CLEAR(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .clear_start(clear_start), .clear_busy(clear_busy),
        .scroll_delay(scroll_delay), .y(y), .bg_x_offset(bg_x_offset),
        .tile_step(tile_step), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [AW-1:0] ch_addr(input int i);
        return 16'(32'h0100 * (i + 1) + 32'h000A);
    endfunction

    function automatic logic [DW-1:0] ch_data(input int i);
        return 32'hD0DE_0000 | 32'(i);
    endfunction

    task automatic do_reset(input logic [31:0] dly, input logic [9:0] yv);
        reset        = 1'b1;
        enable       = 1'b1;
        req_valid    = '0;
        clear_start  = 1'b0;
        scroll_delay = dly;
        y            = yv;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        n_vec++;
        if ({req_ready, clear_busy, bg_x_offset, tile_step, ram_we} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy=%b busy=%b off=%0d ts=%b we=%b, want all 0",
                     req_ready, clear_busy, bg_x_offset, tile_step, ram_we);
        end
        n_vec++;
        if ({ram_addr, ram_data} !== '0) begin
            n_err++;
            $display("FAIL reset_bus: got addr=%h data=%h, want 0", ram_addr, ram_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_clear;
        int exp_a;
        int busy_cyc;
        int guard;
        do_reset(32'hFFFF_FFFF, 10'd0);
        @(posedge clk); #1;
        clear_start = 1'b1;
        req_valid   = 3'b111;
        #1;
        n_vec++;
        if (req_ready !== 3'b000 || clear_busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_vs_req: got rdy=%b busy=%b, want 000 0", req_ready, clear_busy);
        end
        @(posedge clk); #1;
        clear_start = 1'b0;
        #1;
        exp_a = 0; busy_cyc = 0; guard = 0;
        while (clear_busy === 1'b1 && guard < 1300) begin
            n_vec++;
            if ({ram_we, ram_addr, ram_data, req_ready} !== {1'b1, 16'(exp_a), 32'h0, 3'b000}) begin
                n_err++;
                $display("FAIL clear_word: got we=%b addr=%0d data=%h rdy=%b, want 1 %0d 0 000",
                         ram_we, ram_addr, ram_data, req_ready, exp_a);
            end
            exp_a++; busy_cyc++; guard++;
            @(posedge clk); #2;
        end
        n_vec++;
        if (busy_cyc != 1200) begin
            n_err++;
            $display("FAIL clear_len: got %0d busy cycles, want 1200", busy_cyc);
        end
        n_vec++;
        if (ram_we !== 1'b0 || req_ready !== 3'b001) begin
            n_err++;
            $display("FAIL post_clear_grant: got we=%b rdy=%b, want 0 001", ram_we, req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        n_vec++;
        if (ram_we !== 1'b1 || ram_addr !== ch_addr(0) || ram_data !== ch_data(0)) begin
            n_err++;
            $display("FAIL post_clear_write: got we=%b addr=%h data=%h, want 1 %h %h",
                     ram_we, ram_addr, ram_data, ch_addr(0), ch_data(0));
        end
    endtask

    task automatic test_reset_mid_clear;
        do_reset(32'hFFFF_FFFF, 10'd0);
        @(posedge clk); #1;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (clear_busy !== 1'b0 || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL abort_clear: got busy=%b we=%b, want 0 0", clear_busy, ram_we);
        end
        @(posedge clk); #1;
        reset       = 1'b0;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        #1;
        n_vec++;
        if (clear_busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'd0) begin
            n_err++;
            $display("FAIL restart_clear: got busy=%b we=%b addr=%0d, want 1 1 0",
                     clear_busy, ram_we, ram_addr);
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_rdy;
        do_reset(32'hFFFF_FFFF, 10'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            req_valid = (k < 6) ? 3'b111 : 3'b000;
            #1;
            exp_rdy = (k < 6) ? 3'(1 << (k % 3)) : 3'b000;
            n_vec++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b, want %b", k, req_ready, exp_rdy);
            end
            n_vec++;
            if (k == 0 || k == 7) begin
                if (ram_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL rr_idle_we[%0d]: got %b, want 0", k, ram_we);
                end
            end else if (ram_we !== 1'b1 || ram_addr !== ch_addr((k - 1) % 3)
                         || ram_data !== ch_data((k - 1) % 3)) begin
                n_err++;
                $display("FAIL rr_write[%0d]: got we=%b addr=%h data=%h, want 1 %h %h", k,
                         ram_we, ram_addr, ram_data, ch_addr((k - 1) % 3), ch_data((k - 1) % 3));
            end
        end
    endtask

    task automatic test_pointer;
        logic [2:0] sv_valid [10];
        logic [2:0] sv_rdy   [10];
        logic       sv_we    [10];
        int         sv_ch    [10];
        sv_valid = '{3'b100, 3'b000, 3'b011, 3'b000, 3'b101, 3'b110, 3'b000, 3'b011, 3'b000, 3'b000};
        sv_rdy   = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b100, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
        sv_we    = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
        sv_ch    = '{0,      2,      0,      0,      0,      2,      1,      0,      0,      0};
        do_reset(32'hFFFF_FFFF, 10'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            req_valid = sv_valid[k];
            #1;
            n_vec++;
            if (req_ready !== sv_rdy[k]) begin
                n_err++;
                $display("FAIL ptr_grant[%0d]: got %b, want %b", k, req_ready, sv_rdy[k]);
            end
            n_vec++;
            if (ram_we !== sv_we[k]) begin
                n_err++;
                $display("FAIL ptr_we[%0d]: got %b, want %b", k, ram_we, sv_we[k]);
            end else if (sv_we[k] && (ram_addr !== ch_addr(sv_ch[k]) || ram_data !== ch_data(sv_ch[k]))) begin
                n_err++;
                $display("FAIL ptr_write[%0d]: got addr=%h data=%h, want %h %h", k,
                         ram_addr, ram_data, ch_addr(sv_ch[k]), ch_data(sv_ch[k]));
            end
        end
    endtask

    task automatic test_scroll;
        logic [9:0] ytbl [4];
        logic [9:0] y_edge;
        logic [3:0] exp_off;
        logic       exp_ts;
        ytbl = '{10'd10, 10'd31, 10'd32, 10'd100};
        do_reset(32'd3, 10'd10);
        y_edge = 10'd10;
        for (int n = 1; n <= 140; n++) begin
            @(posedge clk); #1;
            exp_off = (y_edge < 10'd32) ? 4'd0 : 4'(((n - 1) / 4) % 16);
            exp_ts  = (n % 64 == 0);
            n_vec++;
            if (bg_x_offset !== exp_off) begin
                n_err++;
                $display("FAIL scroll_off[%0d]: got %0d, want %0d (y=%0d)", n, bg_x_offset, exp_off, y_edge);
            end
            n_vec++;
            if (tile_step !== exp_ts) begin
                n_err++;
                $display("FAIL tile_step[%0d]: got %b, want %b", n, tile_step, exp_ts);
            end
            y_edge = ytbl[n % 4];
            y      = y_edge;
        end
    endtask

    task automatic test_freeze;
        do_reset(32'd3, 10'd100);
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (bg_x_offset !== 4'd1) begin
            n_err++;
            $display("FAIL freeze_pre: got %0d, want 1", bg_x_offset);
        end
        enable    = 1'b0;
        req_valid = 3'b111;
        #1;
        n_vec++;
        if (req_ready !== 3'b000 || ram_we !== 1'b0 || tile_step !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_strobes: got rdy=%b we=%b ts=%b, want 000 0 0", req_ready, ram_we, tile_step);
        end
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if (bg_x_offset !== 4'd1) begin
            n_err++;
            $display("FAIL freeze_hold: got %0d, want 1", bg_x_offset);
        end
        enable    = 1'b1;
        req_valid = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bg_x_offset !== 4'd2) begin
            n_err++;
            $display("FAIL freeze_resume_a: got %0d, want 2", bg_x_offset);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bg_x_offset !== 4'd2) begin
            n_err++;
            $display("FAIL freeze_resume_b: got %0d, want 2", bg_x_offset);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bg_x_offset !== 4'd3) begin
            n_err++;
            $display("FAIL freeze_resume_c: got %0d, want 3", bg_x_offset);
        end
    endtask

    task automatic test_enable_gap;
        int n_wr;
        int gap;
        int guard;
        do_reset(32'hFFFF_FFFF, 10'd0);
        @(posedge clk); #1;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        n_wr = 0; gap = 0; guard = 0;
        while (guard < 1400 && n_wr < 1200) begin
            if (n_wr == 500 && gap < 20) begin
                enable = 1'b0;
                gap++;
            end else begin
                enable = 1'b1;
            end
            #1;
            if (!enable) begin
                n_vec++;
                if (ram_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL gap_quiet: got we=%b addr=%0d, want 0", ram_we, ram_addr);
                end
            end else if (ram_we === 1'b1) begin
                n_vec++;
                if (ram_addr !== 16'(n_wr) || ram_data !== 32'h0) begin
                    n_err++;
                    $display("FAIL gap_word: got addr=%0d data=%h, want %0d 0", ram_addr, ram_data, n_wr);
                end
                n_wr++;
            end
            guard++;
            @(posedge clk); #1;
        end
        enable = 1'b1;
        #1;
        n_vec++;
        if (n_wr != 1200 || gap != 20) begin
            n_err++;
            $display("FAIL gap_total: got %0d writes gap=%0d, want 1200 20", n_wr, gap);
        end
        n_vec++;
        if (clear_busy !== 1'b0) begin
            n_err++;
            $display("FAIL gap_end: got busy=%b, want 0", clear_busy);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        enable       = 1'b1;
        req_valid    = '0;
        clear_start  = 1'b0;
        scroll_delay = 32'hFFFF_FFFF;
        y            = '0;
        for (int i = 0; i < N_CH; i++) begin
            req_addr[i*AW +: AW] = ch_addr(i);
            req_data[i*DW +: DW] = ch_data(i);
        end
        test_reset;
        test_clear;
        test_reset_mid_clear;
        test_round_robin;
        test_pointer;
        test_scroll;
        test_freeze;
        test_enable_gap;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
